// File: rtl/tx_sched.sv
// tx_sched: bus-access scheduler; times rx idle in bit periods, adds priority + backoff slot, grants tx_permit (LFSR backoff with TX_SCHED_LFSR_EN).
// Latency: tx_permit rises one clk after PERMIT is entered; all outputs registered, no input-to-output comb path.
// Backpressure: none; the serializer takes the grant via tx_en, and unread=0 holds the grant off in SLOT.
module tx_sched #(
    parameter int          BACKOFF_MAX_EXP = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] div_ls,
    input  logic [7:0]  idle_len,
    input  logic [9:0]  permit_len,
    input  logic        rx,
    input  logic        unread,
    input  logic        tx_en,
    input  logic        cd,
    input  logic        cd_err,
    input  logic        read_done,
    input  logic        abort,
    output logic        tx_permit,
    output logic        bus_idle,
    output logic [2:0]  backoff_exp
);

    typedef enum logic [1:0] {WAIT_IDLE, SLOT, PERMIT, BUSY} state_t;

    localparam logic [2:0]  EXP_MAX      = 3'(BACKOFF_MAX_EXP);
    localparam logic [10:0] IDLE_CNT_MAX = 11'd1023;
    localparam logic [10:0] SLOT_CNT_MAX = 11'd2047;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] div_cnt;
    logic [10:0] bit_cnt;
    logic [10:0] bit_cnt_inc;
    logic [10:0] slot_tgt;
    logic [10:0] backoff_val;
    logic        line_quiet;
    logic        bit_tick;
    logic        idle_hit;
    logic        slot_hit;
    logic        slot_enter;
    logic        tx_permit_d;
    logic        bus_idle_d;

    assign line_quiet  = rx && !tx_en;
    assign bit_tick    = line_quiet && (div_cnt >= div_ls);
    assign bit_cnt_inc = bit_cnt + 11'd1;
    // Compare against the post-increment count so the threshold is met on the tick itself.
    assign idle_hit    = bit_tick && (bit_cnt_inc >= {3'b000, idle_len});
    assign slot_hit    = (bit_cnt >= slot_tgt) || (bit_tick && (bit_cnt_inc >= slot_tgt));
    assign slot_enter  = (state == WAIT_IDLE) && (state_nxt == SLOT);

`ifdef TX_SCHED_LFSR_EN
    logic [15:0] lfsr;
    logic [9:0]  bo_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign bo_mask     = (10'd1 << backoff_exp) - 10'd1;
    assign backoff_val = {1'b0, lfsr[9:0] & bo_mask};
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign backoff_val = {7'b0000000, backoff_exp, 1'b0};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= 16'd0;
        end else if (!line_quiet || abort || bit_tick) begin
            div_cnt <= 16'd0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= 11'd0;
        end else if (!line_quiet || abort || slot_enter) begin
            bit_cnt <= 11'd0;
        end else if (bit_tick) begin
            if (state == WAIT_IDLE) begin
                bit_cnt <= (bit_cnt >= IDLE_CNT_MAX) ? IDLE_CNT_MAX : bit_cnt_inc;
            end else begin
                bit_cnt <= (bit_cnt == SLOT_CNT_MAX) ? SLOT_CNT_MAX : bit_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_tgt <= 11'd0;
        end else if (slot_enter) begin
            slot_tgt <= {1'b0, permit_len} + backoff_val;
        end
    end

    // Completion or give-up resets the window and outranks a simultaneous collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            backoff_exp <= 3'd0;
        end else if (abort || read_done || cd_err) begin
            backoff_exp <= 3'd0;
        end else if (cd && (backoff_exp < EXP_MAX)) begin
            backoff_exp <= backoff_exp + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = WAIT_IDLE;
        end else begin
            case (state)
                WAIT_IDLE: if (idle_hit) state_nxt = SLOT;
                SLOT: begin
                    if (!rx)                      state_nxt = WAIT_IDLE;
                    else if (slot_hit && unread)  state_nxt = PERMIT;
                end
                // The serializer's own drive shows up on rx, so tx_en is looked at first.
                PERMIT: begin
                    if (tx_en)                    state_nxt = BUSY;
                    else if (!rx)                 state_nxt = WAIT_IDLE;
                end
                BUSY: if (!tx_en) state_nxt = WAIT_IDLE;
                default: state_nxt = WAIT_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_permit_d = (state == PERMIT) && (state_nxt == PERMIT);
        bus_idle_d  = (state_nxt == SLOT) || (state_nxt == PERMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_permit <= 1'b0;
            bus_idle  <= 1'b0;
        end else begin
            tx_permit <= tx_permit_d;
            bus_idle  <= bus_idle_d;
        end
    end

endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched: idle timing, slot/backoff, abort and async reset.
module tb_tx_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] div_ls;
    logic [7:0]  idle_len;
    logic [9:0]  permit_len;
    logic        rx;
    logic        unread;
    logic        tx_en;
    logic        cd;
    logic        cd_err;
    logic        read_done;
    logic        abort;
    logic        tx_permit;
    logic        bus_idle;
    logic [2:0]  backoff_exp;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tx_sched dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .div_ls      (div_ls),
        .idle_len    (idle_len),
        .permit_len  (permit_len),
        .rx          (rx),
        .unread      (unread),
        .tx_en       (tx_en),
        .cd          (cd),
        .cd_err      (cd_err),
        .read_done   (read_done),
        .abort       (abort),
        .tx_permit   (tx_permit),
        .bus_idle    (bus_idle),
        .backoff_exp (backoff_exp)
    );

    // Holds reset for two cycles, releases it on a negedge.
    task automatic do_reset(input logic [15:0] d, input logic [7:0] il,
                            input logic [9:0] pl, input logic ur);
        reset_n    = 1'b0;
        div_ls     = d;
        idle_len   = il;
        permit_len = pl;
        rx         = 1'b1;
        unread     = ur;
        tx_en      = 1'b0;
        cd         = 1'b0;
        cd_err     = 1'b0;
        read_done  = 1'b0;
        abort      = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Counts clk edges until the selected output is seen high; -1 if the bound expires.
    task automatic wait_rise(input bit sel_permit, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if ((sel_permit ? tx_permit : bus_idle) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_cd();
        cd = 1'b1;
        @(negedge clk);
        cd = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if (tx_permit !== 1'b0) begin n_fail++; $display("FAIL reset_tx_permit: got %b expected 0", tx_permit); end
        n_chk++; if (bus_idle !== 1'b0) begin n_fail++; $display("FAIL reset_bus_idle: got %b expected 0", bus_idle); end
        n_chk++; if (backoff_exp !== 3'd0) begin n_fail++; $display("FAIL reset_backoff_exp: got %0d expected 0", backoff_exp); end
    endtask

    task automatic test_basic();
        int n;
        do_reset(16'd3, 8'd10, 10'd2, 1'b1);
        wait_rise(1'b0, 200, n);
        n_chk++; if (n != 40) begin n_fail++; $display("FAIL basic_idle_latency: got %0d expected 40", n); end
        n_chk++; if (tx_permit !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_permit: got %b expected 0", tx_permit); end
        wait_rise(1'b1, 200, n);
        n_chk++; if (n != 9) begin n_fail++; $display("FAIL basic_permit_latency: got %0d expected 9", n); end
        n_chk++; if (bus_idle !== 1'b1) begin n_fail++; $display("FAIL basic_idle_in_permit: got %b expected 1", bus_idle); end
        tx_en = 1'b1;
        @(negedge clk);
        n_chk++; if (tx_permit !== 1'b0) begin n_fail++; $display("FAIL basic_permit_drop: got %b expected 0", tx_permit); end
        n_chk++; if (bus_idle !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle: got %b expected 0", bus_idle); end
        tx_en = 1'b0;
    endtask

    task automatic test_rx_glitch();
        int n;
        do_reset(16'd3, 8'd10, 10'd2, 1'b1);
        repeat (29) @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        wait_rise(1'b0, 200, n);
        n_chk++; if (n != 40) begin n_fail++; $display("FAIL glitch_idle_restart: got %0d expected 40", n); end
        n_chk++; if (tx_permit !== 1'b0) begin n_fail++; $display("FAIL glitch_no_permit: got %b expected 0", tx_permit); end
    endtask

    task automatic test_backoff();
        int n;
        do_reset(16'd3, 8'd10, 10'd2, 1'b1);
        tx_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            pulse_cd();
            n_chk++; if (backoff_exp !== 3'(i)) begin n_fail++; $display("FAIL backoff_grow: got %0d expected %0d", backoff_exp, i); end
        end
        tx_en = 1'b0;
        wait_rise(1'b0, 200, n);
        n_chk++; if (n != 40) begin n_fail++; $display("FAIL backoff_idle_latency: got %0d expected 40", n); end
        wait_rise(1'b1, 200, n);
        n_chk++; if (n != 33) begin n_fail++; $display("FAIL backoff_slot_extended: got %0d expected 33", n); end
        n_chk++; if (backoff_exp !== 3'd3) begin n_fail++; $display("FAIL backoff_hold: got %0d expected 3", backoff_exp); end
        tx_en = 1'b1;
        @(negedge clk);
        read_done = 1'b1;
        @(negedge clk);
        read_done = 1'b0;
        n_chk++; if (backoff_exp !== 3'd0) begin n_fail++; $display("FAIL backoff_read_done: got %0d expected 0", backoff_exp); end
        pulse_cd();
        n_chk++; if (backoff_exp !== 3'd1) begin n_fail++; $display("FAIL backoff_regrow: got %0d expected 1", backoff_exp); end
        cd = 1'b1;
        read_done = 1'b1;
        @(negedge clk);
        cd = 1'b0;
        read_done = 1'b0;
        n_chk++; if (backoff_exp !== 3'd0) begin n_fail++; $display("FAIL backoff_reset_wins: got %0d expected 0", backoff_exp); end
        tx_en = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset(16'd3, 8'd10, 10'd2, 1'b1);
        tx_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            pulse_cd();
            n_chk++; if (backoff_exp !== 3'((i < 4) ? i : 4)) begin
                n_fail++; $display("FAIL saturate_step%0d: got %0d expected %0d", i, backoff_exp, (i < 4) ? i : 4);
            end
        end
        cd_err = 1'b1;
        @(negedge clk);
        cd_err = 1'b0;
        n_chk++; if (backoff_exp !== 3'd0) begin n_fail++; $display("FAIL saturate_cd_err: got %0d expected 0", backoff_exp); end
        tx_en = 1'b0;
    endtask

    task automatic test_unread_hold();
        int n;
        do_reset(16'd3, 8'd10, 10'd2, 1'b0);
        wait_rise(1'b0, 200, n);
        n_chk++; if (n != 40) begin n_fail++; $display("FAIL unread_idle_latency: got %0d expected 40", n); end
        repeat (20) @(negedge clk);
        n_chk++; if (tx_permit !== 1'b0 || bus_idle !== 1'b1) begin
            n_fail++; $display("FAIL unread_hold: got permit=%b idle=%b expected permit=0 idle=1", tx_permit, bus_idle);
        end
        unread = 1'b1;
        @(negedge clk);
        n_chk++; if (tx_permit !== 1'b0) begin n_fail++; $display("FAIL unread_permit_early: got %b expected 0", tx_permit); end
        @(negedge clk);
        n_chk++; if (tx_permit !== 1'b1) begin n_fail++; $display("FAIL unread_permit: got %b expected 1", tx_permit); end
    endtask

    task automatic test_fast();
        int n;
        do_reset(16'd0, 8'd0, 10'd0, 1'b1);
        wait_rise(1'b0, 50, n);
        n_chk++; if (n != 1) begin n_fail++; $display("FAIL fast_idle_latency: got %0d expected 1", n); end
        wait_rise(1'b1, 50, n);
        n_chk++; if (n != 2) begin n_fail++; $display("FAIL fast_permit_latency: got %0d expected 2", n); end
        do_reset(16'd3, 8'd0, 10'd2, 1'b1);
        wait_rise(1'b0, 50, n);
        n_chk++; if (n != 4) begin n_fail++; $display("FAIL zero_idle_latency: got %0d expected 4", n); end
        do_reset(16'd0, 8'd5, 10'd1, 1'b1);
        wait_rise(1'b0, 50, n);
        n_chk++; if (n != 5) begin n_fail++; $display("FAIL div0_idle_latency: got %0d expected 5", n); end
    endtask

    task automatic test_abort();
        int n;
        do_reset(16'd3, 8'd10, 10'd2, 1'b1);
        pulse_cd();
        pulse_cd();
        wait_rise(1'b0, 200, n);
        n_chk++; if (n != 38) begin n_fail++; $display("FAIL abort_idle_latency: got %0d expected 38", n); end
        wait_rise(1'b1, 200, n);
        n_chk++; if (n != 25) begin n_fail++; $display("FAIL abort_slot_backoff2: got %0d expected 25", n); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_chk++; if (tx_permit !== 1'b0) begin n_fail++; $display("FAIL abort_permit: got %b expected 0", tx_permit); end
        n_chk++; if (bus_idle !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b expected 0", bus_idle); end
        n_chk++; if (backoff_exp !== 3'd0) begin n_fail++; $display("FAIL abort_backoff: got %0d expected 0", backoff_exp); end
        wait_rise(1'b0, 200, n);
        n_chk++; if (n != 40) begin n_fail++; $display("FAIL abort_restart: got %0d expected 40", n); end
    endtask

    task automatic test_reset_mid_slot();
        int n;
        do_reset(16'd3, 8'd10, 10'd2, 1'b1);
        pulse_cd();
        wait_rise(1'b0, 200, n);
        n_chk++; if (n != 39) begin n_fail++; $display("FAIL midslot_idle_latency: got %0d expected 39", n); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if (tx_permit !== 1'b0 || bus_idle !== 1'b0) begin
            n_fail++; $display("FAIL midslot_async_outputs: got permit=%b idle=%b expected 0 0", tx_permit, bus_idle);
        end
        n_chk++; if (backoff_exp !== 3'd0) begin n_fail++; $display("FAIL midslot_async_backoff: got %0d expected 0", backoff_exp); end
        @(negedge clk);
        reset_n = 1'b1;
        wait_rise(1'b0, 200, n);
        n_chk++; if (n != 40) begin n_fail++; $display("FAIL midslot_full_idle: got %0d expected 40", n); end
        n_chk++; if (tx_permit !== 1'b0) begin n_fail++; $display("FAIL midslot_no_permit: got %b expected 0", tx_permit); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rx_glitch();
        test_backoff();
        test_saturate();
        test_unread_hold();
        test_fast();
        test_abort();
        test_reset_mid_slot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
